// File: rtl/mux_key_loader_pkg.sv
// Shared types and constants for the serial key loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mux_key_loader_pkg;

    // Load sequence: collect key bits, collect parity, verify, then hold.
    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        PARITY,
        CHECK,
        DONE
    } state_t;

    // Each downstream 4:1 mux takes a {key_1,key_0} select pair.
    localparam int BITS_PER_MUX = 2;

endpackage

// File: rtl/mux_key_loader_if.sv
// Serial key stream in, committed key and load status out.
// Latency: n/a (signal bundle only).
// Backpressure: key_in_ready gates key_in_valid; beats offered without ready are dropped.
// Ports: load_start, key_in, key_in_valid (source -> loader);
//        key_in_ready, key_out, key_valid, busy, err (loader -> source / mux bank).
interface mux_key_loader_if #(
    parameter int KEY_WIDTH = 8
);
    import mux_key_loader_pkg::*;

    logic                 load_start;
    logic                 key_in;
    logic                 key_in_valid;
    logic                 key_in_ready;
    logic [KEY_WIDTH-1:0] key_out;
    logic                 key_valid;
    logic                 busy;
    logic                 err;

    // Key source side.
    modport master (
        output load_start, key_in, key_in_valid,
        input  key_in_ready, key_out, key_valid, busy, err
    );

    // Loader side.
    modport slave (
        input  load_start, key_in, key_in_valid,
        output key_in_ready, key_out, key_valid, busy, err
    );

endinterface

// File: rtl/mux_key_loader_key_shift_reg.sv
// Shadow shift register collecting the serial key, LSB first, with XOR parity.
// Latency: one edge per shifted bit; parity is combinational from q.
// Backpressure: none; shifts only when shift_en is high.
// Ports: clk, rst (sync, active high), clear (sync), shift_en, d (serial in),
//        q (WIDTH-bit shadow), parity (^q).
module key_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             d,
    output logic [WIDTH-1:0] q,
    output logic             parity
);

    logic [WIDTH-1:0] q_r;

    // New bits enter at the MSB and move down, so after WIDTH shifts the
    // first bit received sits in bit 0 (equivalent to writing shadow[count]).
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            q_r <= '0;
        end else if (shift_en) begin
            q_r <= {d, q_r[WIDTH-1:1]};
        end
    end

    assign q      = q_r;
    assign parity = ^q_r;

endmodule

// File: rtl/mux_key_loader.sv
// Serial key loader driving the select pairs of a bank of 4:1 locking muxes.
// Latency: key_out/key_valid update on the 2nd edge after the parity beat is accepted.
// Backpressure: key_in_ready high only while collecting key or parity bits; stalls indefinitely.
// Ports: clk, rst (sync, active high), bus (slave modport: load_start, key_in,
//        key_in_valid, key_in_ready, key_out, key_valid, busy, err).
module mux_key_loader
    import mux_key_loader_pkg::*;
#(
    parameter int NUM_MUX = 4
) (
    input  logic               clk,
    input  logic               rst,
    mux_key_loader_if.slave    bus
);

    localparam int KEY_WIDTH = BITS_PER_MUX * NUM_MUX;
    localparam int CNT_WIDTH = $clog2(KEY_WIDTH + 1);

    state_t                state_q;
    state_t                state_d;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic                  parity_q;
    logic [KEY_WIDTH-1:0]  key_out_q;
    logic                  key_valid_q;
    logic                  err_q;

    logic                  ready;
    logic                  accept;
    logic                  start;
    logic                  shift_en;
    logic                  latch_par;
    logic                  commit;
    logic                  fail;

    logic [KEY_WIDTH-1:0]  shadow;
    logic                  shadow_par;

    assign accept = bus.key_in_valid && ready;

    key_shift_reg #(
        .WIDTH (KEY_WIDTH)
    ) u_shift (
        .clk      (clk),
        .rst      (rst),
        .clear    (start),
        .shift_en (shift_en),
        .d        (bus.key_in),
        .q        (shadow),
        .parity   (shadow_par)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ready     = 1'b0;
        start     = 1'b0;
        shift_en  = 1'b0;
        latch_par = 1'b0;
        commit    = 1'b0;
        fail      = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (bus.load_start) begin
                    start   = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                ready = 1'b1;
                if (accept) begin
                    shift_en = 1'b1;
                    // This beat brings the count to KEY_WIDTH.
                    if (cnt_q == CNT_WIDTH'(KEY_WIDTH - 1)) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                ready = 1'b1;
                if (accept) begin
                    latch_par = 1'b1;
                    state_d   = CHECK;
                end
            end
            CHECK: begin
                // Even parity: data XOR must equal the trailer bit.
                if (shadow_par == parity_q) begin
                    commit = 1'b1;
                end else begin
                    fail = 1'b1;
                end
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (start) begin
            cnt_q <= '0;
        end else if (shift_en) begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else if (latch_par) begin
            parity_q <= bus.key_in;
        end
    end

    // key_out only changes on a verified commit, so the mux bank never
    // sees a partially shifted key.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_out_q   <= '0;
            key_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else if (start) begin
            key_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else if (commit) begin
            key_out_q   <= shadow;
            key_valid_q <= 1'b1;
        end else if (fail) begin
            err_q       <= 1'b1;
        end
    end

    assign bus.key_in_ready = ready;
    assign bus.key_out      = key_out_q;
    assign bus.key_valid    = key_valid_q;
    assign bus.err          = err_q;
    assign bus.busy         = (state_q == SHIFT) || (state_q == PARITY) || (state_q == CHECK);

endmodule

// File: tb/tb_mux_key_loader.sv
// Bench for mux_key_loader: directed loads checked against a transaction-level model.
// Latency: model commits on the edge after all nine bits have been collected.
// Backpressure: driver offers beats every cycle; stalls are explicit.
module tb_mux_key_loader;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mux_key_loader_if #(.KEY_WIDTH(8)) bus ();

    mux_key_loader #(.NUM_MUX(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model: bits collected as a list ----------------
    bit         m_init = 1'b0;
    logic [7:0] m_key;
    logic       m_valid;
    logic       m_err;
    logic       m_coll;   // gathering the 9 serial bits
    logic       m_pend;   // all bits in, verdict lands on the next edge
    logic       mq[$];
    logic [7:0] mk;

    always @(posedge clk) begin
        if (rst) begin
            m_init  = 1'b1;
            m_key   = 8'h00;
            m_valid = 1'b0;
            m_err   = 1'b0;
            m_coll  = 1'b0;
            m_pend  = 1'b0;
            mq.delete();
        end else if (m_init) begin
            if (m_pend) begin
                for (int i = 0; i < 8; i++) mk[i] = mq[i];
                if ((^mk) == mq[8]) begin
                    m_key   = mk;
                    m_valid = 1'b1;
                end else begin
                    m_err = 1'b1;
                end
                m_pend = 1'b0;
            end else if (m_coll) begin
                if (bus.key_in_valid) begin
                    mq.push_back(bus.key_in);
                    if (mq.size() == 9) begin
                        m_coll = 1'b0;
                        m_pend = 1'b1;
                    end
                end
            end else if (bus.load_start) begin
                m_coll  = 1'b1;
                m_err   = 1'b0;
                m_valid = 1'b0;
                mq.delete();
            end
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            check("key_out",      {24'h0, bus.key_out}, {24'h0, m_key});
            check("key_valid",    {31'h0, bus.key_valid}, {31'h0, m_valid});
            check("err",          {31'h0, bus.err}, {31'h0, m_err});
            check("busy",         {31'h0, bus.busy}, {31'h0, (m_coll | m_pend)});
            check("key_in_ready", {31'h0, bus.key_in_ready}, {31'h0, m_coll});
        end
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load();
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
    endtask

    // Sends 8 key bits LSB first then the parity bit; optional stall before
    // bit stall_at and a load_start pulse alongside bit ls_at.
    task automatic send_bits(input logic [7:0] key, input logic par,
                             input int stall_at, input int stall_len, input int ls_at);
        for (int i = 0; i < 9; i++) begin
            if (i == stall_at) begin
                bus.key_in_valid = 1'b0;
                repeat (stall_len) tick();
            end
            bus.key_in       = (i < 8) ? key[i] : par;
            bus.key_in_valid = 1'b1;
            bus.load_start   = (i == ls_at);
            tick();
            bus.load_start   = 1'b0;
        end
        bus.key_in_valid = 1'b0;
        tick();
    endtask

    task automatic expect_out(input string tag, input logic [7:0] key, input logic valid,
                              input logic err, input logic busy);
        check({tag, ".key_out"},   {24'h0, bus.key_out}, {24'h0, key});
        check({tag, ".key_valid"}, {31'h0, bus.key_valid}, {31'h0, valid});
        check({tag, ".err"},       {31'h0, bus.err}, {31'h0, err});
        check({tag, ".busy"},      {31'h0, bus.busy}, {31'h0, busy});
    endtask

    function automatic logic [7:0] mux4(input logic [1:0] sel, input logic [7:0] a,
                                        input logic [7:0] b, input logic [7:0] c,
                                        input logic [7:0] d);
        case (sel)
            2'd0:    return a;
            2'd1:    return b;
            2'd2:    return c;
            default: return d;
        endcase
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] sel;
        logic [7:0] mo;
        rst              = 1'b1;
        bus.load_start   = 1'b0;
        bus.key_in       = 1'b0;
        bus.key_in_valid = 1'b0;

        // 1. reset for two cycles
        tick();
        tick();
        rst = 1'b0;
        expect_out("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        check("reset.ready", {31'h0, bus.key_in_ready}, 32'h0);

        // beats offered while idle are dropped
        bus.key_in       = 1'b1;
        bus.key_in_valid = 1'b1;
        repeat (3) tick();
        bus.key_in_valid = 1'b0;
        expect_out("idle_drop", 8'h00, 1'b0, 1'b0, 1'b0);

        // 2. good load A5 (four ones -> parity 0)
        start_load();
        check("load.ready", {31'h0, bus.key_in_ready}, 32'h1);
        send_bits(8'hA5, 1'b0, -1, 0, -1);
        expect_out("good_a5", 8'hA5, 1'b1, 1'b0, 1'b0);

        // 3. bad parity on 3C keeps A5
        start_load();
        send_bits(8'h3C, 1'b1, -1, 0, -1);
        expect_out("bad_3c", 8'hA5, 1'b0, 1'b1, 1'b0);

        // 4. stall 5 cycles before bit 4, ignored load_start at bit 6
        start_load();
        send_bits(8'h5A, 1'b0, 4, 5, 6);
        expect_out("stall_5a", 8'h5A, 1'b1, 1'b0, 1'b0);

        // 5. reset after four bits, then rst with load_start, then FF
        start_load();
        for (int i = 0; i < 4; i++) begin
            bus.key_in       = 1'b1;
            bus.key_in_valid = 1'b1;
            tick();
        end
        bus.key_in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expect_out("mid_rst", 8'h00, 1'b0, 1'b0, 1'b0);
        rst            = 1'b1;
        bus.load_start = 1'b1;
        tick();
        rst            = 1'b0;
        bus.load_start = 1'b0;
        expect_out("rst_wins", 8'h00, 1'b0, 1'b0, 1'b0);
        start_load();
        send_bits(8'hFF, 1'b0, -1, 0, -1);
        expect_out("good_ff", 8'hFF, 1'b1, 1'b0, 1'b0);

        // 6. key 11_10_01_00 selects in_i on mux i; extra beats after load dropped
        start_load();
        send_bits(8'hE4, 1'b0, -1, 0, -1);
        bus.key_in_valid = 1'b1;
        repeat (2) tick();
        bus.key_in_valid = 1'b0;
        expect_out("good_e4", 8'hE4, 1'b1, 1'b0, 1'b0);
        for (int m = 0; m < 4; m++) begin
            sel = bus.key_out[2*m +: 2];
            mo  = mux4(sel, 8'(16*m + 0), 8'(16*m + 1), 8'(16*m + 2), 8'(16*m + 3));
            check($sformatf("mux%0d", m), {24'h0, mo}, {24'h0, 8'(17*m)});
        end

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
